conv_mac_sequencer: RTL

Sequencer for the 9-lane 3x3 convolution MAC datapath (multiplier -> addertree_stage1/2/3 -> adder_final). It accepts a job of N output pixels, each accumulated over P channel passes. Per pass it streams operand windows into the combinational datapath and owns the pre_output feedback register, including clipping and first-pass clearing. It then presents each finished 13-bit result on a valid/ready output port.

---
 rtl/conv_mac_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: job sequencer for the 9-lane 3x3 convolution MAC
// datapath. It streams operand windows into the external combinational
// datapath, owns the clipped pre_output feedback register, and presents
// each finished pixel on a valid/ready output port.
// Optional feature macro: SEQ_SAT_COUNT_EN (enables the saturation counter).
module conv_mac_sequencer #(
   parameter int NPASS_W = 4,
   parameter int NWIN_W  = 16,
   parameter int ACC_W   = 13
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic [NPASS_W-1:0] cfg_npass,
   input  logic [NWIN_W-1:0]  cfg_nwin,
   input  logic [15:0]        cfg_bias,
   output logic               busy,
   output logic               done,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [71:0]        in_multiplicand9,
   input  logic [71:0]        in_multiplier9,
   output logic [71:0]        dp_multiplicand9,
   output logic [71:0]        dp_multiplier9,
   output logic [15:0]        dp_bias,
   output logic [ACC_W-1:0]   dp_pre_output,
   input  logic [ACC_W:0]     dp_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_data,
   output logic [15:0]        sat_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, OUT, FIN} state_t;

   state_t             state, state_nxt;
   logic [NPASS_W-1:0] npass, pass_cnt;
   logic [NWIN_W-1:0]  nwin, win_cnt;
   logic [15:0]        bias;
   logic [ACC_W-1:0]   acc, clipped;
   logic               hs, start_ok, last_pass, last_win;

   assign start_ok  = (state == IDLE) && cfg_start;
   assign hs        = (state == RUN) && in_valid;
   assign last_pass = (pass_cnt == npass - NPASS_W'(1));
   assign last_win  = (win_cnt == nwin - NWIN_W'(1));

   // Operands reach the datapath only while a window is actually being taken.
   assign dp_multiplicand9 = hs ? in_multiplicand9 : '0;
   assign dp_multiplier9   = hs ? in_multiplier9   : '0;
   assign dp_bias          = (hs && pass_cnt == '0) ? bias : '0;
   // The first pass of every pixel starts from zero, not from the stale acc.
   assign dp_pre_output    = (pass_cnt != '0) ? acc : '0;

   // Clip the datapath sum into the signed ACC_W-bit accumulator range.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      clipped = dp_out[ACC_W-1:0];
      case (dp_out[ACC_W:ACC_W-1])
         2'b01:   clipped = {1'b0, {(ACC_W-1){1'b1}}};
         2'b10:   clipped = {1'b1, {(ACC_W-1){1'b0}}};
         default: clipped = dp_out[ACC_W-1:0];
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state and handshake/status outputs.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: if (cfg_start) state_nxt = (cfg_nwin == '0) ? FIN : RUN;
         RUN: begin
            in_ready = 1'b1;
            if (hs && last_pass) state_nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = last_win ? FIN : RUN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Job configuration, accumulator, counters and output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         npass    <= '0;
         nwin     <= '0;
         bias     <= '0;
         acc      <= '0;
         pass_cnt <= '0;
         win_cnt  <= '0;
         out_data <= '0;
      end else begin
         if (start_ok) begin
            npass    <= (cfg_npass == '0) ? NPASS_W'(1) : cfg_npass;
            nwin     <= cfg_nwin;
            bias     <= cfg_bias;
            acc      <= '0;
            pass_cnt <= '0;
            win_cnt  <= '0;
         end
         if (hs) begin
            acc <= clipped;
            if (last_pass) begin
               out_data <= clipped;
               pass_cnt <= '0;
            end else begin
               pass_cnt <= pass_cnt + NPASS_W'(1);
            end
         end
         if (state == OUT && out_ready) win_cnt <= win_cnt + NWIN_W'(1);
      end
   end

`ifdef SEQ_SAT_COUNT_EN
   logic        clip_hit;
   logic [15:0] sat_q;

   // Top two sum bits disagreeing is exactly the clipping case.
   assign clip_hit = dp_out[ACC_W] ^ dp_out[ACC_W-1];

   // Saturating count of clipped handshakes, cleared per job.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   sat_q <= '0;
      else if (start_ok)                           sat_q <= '0;
      else if (hs && clip_hit && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
   end

   assign sat_cnt = sat_q;
`else
   assign sat_cnt = '0;
`endif

endmodule
